// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join scheduler: join modes, controller states and slot limit.
// The mode decoder folds the reserved encoding onto plain JOIN.
package fork_join_pkg;

    localparam int FJ_MAX_THREADS = 16;

    typedef enum logic [1:0] {
        FJ_JOIN      = 2'd0,
        FJ_JOIN_ANY  = 2'd1,
        FJ_JOIN_NONE = 2'd2
    } fj_mode_e;

    typedef enum logic [1:0] {
        FJ_IDLE,
        FJ_LAUNCH,
        FJ_RUN,
        FJ_DETACHED
    } fj_state_e;

    function automatic fj_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return FJ_JOIN_ANY;
            2'd2:    return FJ_JOIN_NONE;
            default: return FJ_JOIN;
        endcase
    endfunction

endpackage

// File: rtl/fj_watchdog.sv
// Cycle counter for the fork group; expire is high while the count sits on a non-zero limit.
// The counter only runs while enabled, so expire lasts one cycle once the controller reacts.
module fj_watchdog #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expire
);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire = enable && (limit != '0) && (count_q == limit);

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join scheduler: launches a masked group of workers, tracks completion and
// reports join, all-done, abort and watchdog timeout as registered one-cycle pulses.
module fork_join_ctrl
    import fork_join_pkg::*;
#(
    parameter int N_THREADS = 4,
    parameter int TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           mode_i,
    input  logic [N_THREADS-1:0] mask_i,
    input  logic [TMO_W-1:0]     timeout_cycles_i,
    input  logic                 abort_i,
    input  logic [N_THREADS-1:0] done_i,
    output logic [N_THREADS-1:0] launch_o,
    output logic [N_THREADS-1:0] active_o,
    output logic [N_THREADS-1:0] kill_o,
    output logic                 joined_o,
    output logic                 all_done_o,
    output logic                 aborted_o,
    output logic                 timeout_o,
    output logic                 idle_o
);

    fj_state_e            state_q, state_d;
    fj_mode_e             mode_q;
    logic [N_THREADS-1:0] mask_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [N_THREADS-1:0] active_q, active_d;
    logic [N_THREADS-1:0] launch_q, launch_d;
    logic [N_THREADS-1:0] kill_q, kill_d;
    logic                 joined_q, joined_d;
    logic                 all_done_q, all_done_d;
    logic                 aborted_q, aborted_d;
    logic                 timeout_q, timeout_d;
    logic                 cfg_load;
    logic                 wd_clear, wd_enable, wd_expire;
    logic [N_THREADS-1:0] live;
    logic                 any_hit, finished;

    assign wd_clear  = (state_q == FJ_LAUNCH);
    assign wd_enable = (state_q == FJ_RUN) || (state_q == FJ_DETACHED);

    fj_watchdog #(
        .TMO_W(TMO_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (wd_clear),
        .enable(wd_enable),
        .limit (tmo_q),
        .expire(wd_expire)
    );

    // Threads still running after this cycle's completions are taken into account.
    assign live     = active_q & ~done_i;
    assign any_hit  = |(done_i & active_q);
    assign finished = (live == '0);

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        launch_d   = '0;
        kill_d     = '0;
        joined_d   = 1'b0;
        all_done_d = 1'b0;
        aborted_d  = 1'b0;
        timeout_d  = 1'b0;
        cfg_load   = 1'b0;

        case (state_q)
            FJ_IDLE: begin
                if (start_i) begin
                    if (mask_i != '0) begin
                        cfg_load = 1'b1;
                        launch_d = mask_i;
                        joined_d = (decode_mode(mode_i) == FJ_JOIN_NONE);
                        state_d  = FJ_LAUNCH;
                    end else begin
                        joined_d   = 1'b1;
                        all_done_d = 1'b1;
                    end
                end
            end

            FJ_LAUNCH: begin
                active_d = mask_q;
                state_d  = (mode_q == FJ_JOIN_NONE) ? FJ_DETACHED : FJ_RUN;
            end

            FJ_RUN, FJ_DETACHED: begin
                active_d = live;
                // A final completion landing on the timeout match still counts as completion.
                if (abort_i || (wd_expire && !finished)) begin
                    kill_d    = live;
                    aborted_d = 1'b1;
                    timeout_d = !abort_i;
                    active_d  = '0;
                    state_d   = FJ_IDLE;
                end else if (state_q == FJ_DETACHED) begin
                    if (finished) begin
                        all_done_d = 1'b1;
                        state_d    = FJ_IDLE;
                    end
                end else if (mode_q == FJ_JOIN_ANY) begin
                    if (any_hit) begin
                        joined_d   = 1'b1;
                        all_done_d = finished;
                        state_d    = finished ? FJ_IDLE : FJ_DETACHED;
                    end
                end else if (finished) begin
                    joined_d   = 1'b1;
                    all_done_d = 1'b1;
                    state_d    = FJ_IDLE;
                end
            end

            default: begin
                active_d = '0;
                state_d  = FJ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FJ_IDLE;
            mode_q     <= FJ_JOIN;
            mask_q     <= '0;
            tmo_q      <= '0;
            active_q   <= '0;
            launch_q   <= '0;
            kill_q     <= '0;
            joined_q   <= 1'b0;
            all_done_q <= 1'b0;
            aborted_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            launch_q   <= launch_d;
            kill_q     <= kill_d;
            joined_q   <= joined_d;
            all_done_q <= all_done_d;
            aborted_q  <= aborted_d;
            timeout_q  <= timeout_d;
            if (cfg_load) begin
                mode_q <= decode_mode(mode_i);
                mask_q <= mask_i;
                tmo_q  <= timeout_cycles_i;
            end
        end
    end

    assign launch_o   = launch_q;
    assign active_o   = active_q;
    assign kill_o     = kill_q;
    assign joined_o   = joined_q;
    assign all_done_o = all_done_q;
    assign aborted_o  = aborted_q;
    assign timeout_o  = timeout_q;
    assign idle_o     = (state_q == FJ_IDLE);

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: each fork group is resolved up front from done/abort/timeout
// times (earliest terminating event wins) and the expected pulses are queued for the monitor.
module tb_fork_join_ctrl;

    localparam int N     = 4;
    localparam int TW    = 16;
    localparam int NEVER = 1 << 28;

    typedef struct {
        int         cyc;
        logic [3:0] launch;
        logic [3:0] kill;
        logic [3:0] active;
        bit         chk_active;
        bit         joined;
        bit         all_done;
        bit         aborted;
        bit         timeout;
        bit         idle;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [1:0]    mode_i;
    logic [N-1:0]  mask_i;
    logic [TW-1:0] timeout_cycles_i;
    logic          abort_i;
    logic [N-1:0]  done_i;
    logic [N-1:0]  launch_o, active_o, kill_o;
    logic          joined_o, all_done_o, aborted_o, timeout_o, idle_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_ev;
    int   dv[4];

    fork_join_ctrl #(.N_THREADS(N), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .mask_i(mask_i),
        .timeout_cycles_i(timeout_cycles_i), .abort_i(abort_i), .done_i(done_i),
        .launch_o(launch_o), .active_o(active_o), .kill_o(kill_o), .joined_o(joined_o),
        .all_done_o(all_done_o), .aborted_o(aborted_o), .timeout_o(timeout_o), .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic checkOutput(input exp_t ev);
        cmp("event_cycle", cyc, ev.cyc);
        cmp("launch_o", {28'd0, launch_o}, {28'd0, ev.launch});
        cmp("kill_o", {28'd0, kill_o}, {28'd0, ev.kill});
        cmp("joined_o", {31'd0, joined_o}, {31'd0, ev.joined});
        cmp("all_done_o", {31'd0, all_done_o}, {31'd0, ev.all_done});
        cmp("aborted_o", {31'd0, aborted_o}, {31'd0, ev.aborted});
        cmp("timeout_o", {31'd0, timeout_o}, {31'd0, ev.timeout});
        cmp("idle_o", {31'd0, idle_o}, {31'd0, ev.idle});
        if (ev.chk_active) cmp("active_o", {28'd0, active_o}, {28'd0, ev.active});
    endtask

    // Monitor: any visible pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && (|{launch_o, kill_o, joined_o, all_done_o, aborted_o, timeout_o})) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse actual=l%0h k%0h j%0b a%0b ab%0b t%0b required=none (cycle %0d)",
                         launch_o, kill_o, joined_o, all_done_o, aborted_o, timeout_o, cyc);
            end else begin
                mon_ev = sb.pop_front();
                checkOutput(mon_ev);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        start_i          = 1'b0;
        mode_i           = 2'd0;
        mask_i           = '0;
        timeout_cycles_i = '0;
        abort_i          = 1'b0;
        done_i           = '0;
    endtask

    task automatic drainCheck(input string name);
        stepCycle();
        cmp(name, sb.size(), 0);
        sb.delete();
    endtask

    // Relative times are counted from the start cycle; a_rel/stray_rel < 0 means none.
    task automatic applyStimulus(input logic [3:0] mask, input logic [1:0] mode, input logic [15:0] tmo,
                                 input int d_rel[4], input int a_rel, input int stray_rel);
        int s, fc, e, c_all, c_any, m, a_abs;
        int d[4];
        bit is_tmo, early;
        logic [1:0] eff_mode;
        logic [3:0] kill_m, act_any, dn;
        exp_t ev;
        s = cyc;
        eff_mode = (mode == 2'd3) ? 2'd0 : mode;
        if (mask == 4'd0) begin
            ev = '{cyc: s + 1, launch: 4'd0, kill: 4'd0, active: 4'd0, chk_active: 1'b1,
                   joined: 1'b1, all_done: 1'b1, aborted: 1'b0, timeout: 1'b0, idle: 1'b1};
            sb.push_back(ev);
            start_i = 1'b1; mask_i = 4'd0; mode_i = mode;
            stepCycle();
            clearInputs();
            drainCheck("pending_after_empty_start");
            return;
        end
        fc = s + 2;
        c_all = 0;
        c_any = NEVER;
        for (int i = 0; i < 4; i++) begin
            d[i] = (d_rel[i] >= NEVER) ? NEVER : s + d_rel[i];
            if (mask[i]) begin
                if (d[i] > c_all) c_all = d[i];
                if (d[i] < c_any) c_any = d[i];
            end
        end
        m     = (tmo != 16'd0) ? fc + int'(tmo) : NEVER;
        a_abs = (a_rel >= 0 && s + a_rel >= fc) ? s + a_rel : NEVER;
        e = c_all; is_tmo = 1'b0; early = 1'b0;
        if (m < c_all) begin e = m; is_tmo = 1'b1; early = 1'b1; end
        if (a_abs <= e) begin e = a_abs; is_tmo = 1'b0; early = 1'b1; end
        if (e >= NEVER) begin
            checks++; errors++;
            $display("[TB] FAIL plan_unbounded actual=never_ends required=bounded");
            return;
        end
        kill_m = '0; act_any = '0;
        for (int i = 0; i < 4; i++) begin
            kill_m[i]  = mask[i] && (d[i] > e);
            act_any[i] = mask[i] && (d[i] > c_any);
        end
        ev = '{cyc: s + 1, launch: mask, kill: 4'd0, active: 4'd0, chk_active: 1'b0,
               joined: (eff_mode == 2'd2), all_done: 1'b0, aborted: 1'b0, timeout: 1'b0, idle: 1'b0};
        sb.push_back(ev);
        if (eff_mode == 2'd1 && c_any < e) begin
            ev = '{cyc: c_any + 1, launch: 4'd0, kill: 4'd0, active: act_any, chk_active: 1'b1,
                   joined: 1'b1, all_done: 1'b0, aborted: 1'b0, timeout: 1'b0, idle: 1'b0};
            sb.push_back(ev);
        end
        ev = '{cyc: e + 1, launch: 4'd0, kill: early ? kill_m : 4'd0, active: 4'd0, chk_active: 1'b1,
               joined: !early && (eff_mode == 2'd0 || (eff_mode == 2'd1 && c_any == e)),
               all_done: !early, aborted: early, timeout: is_tmo, idle: 1'b1};
        sb.push_back(ev);

        for (int t = s; t <= e; t++) begin
            dn = '0;
            for (int i = 0; i < 4; i++) if (mask[i] && d[i] == t) dn[i] = 1'b1;
            if (t >= fc) dn = dn | (4'($urandom) & ~mask);
            done_i           = dn;
            abort_i          = (a_rel >= 0) && (t == s + a_rel);
            start_i          = (t == s) || (stray_rel > 0 && t == s + stray_rel);
            mask_i           = (t == s) ? mask : 4'($urandom_range(1, 15));
            mode_i           = (t == s) ? mode : 2'($urandom);
            timeout_cycles_i = (t == s) ? tmo : 16'($urandom_range(1, 3));
            stepCycle();
        end
        clearInputs();
        drainCheck("pending_after_group");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int a_rel;
        logic [3:0] mask;
        logic [15:0] tmo;
        clearInputs();
        rst = 1'b1;
        repeat (3) stepCycle();
        rst = 1'b0;
        cmp("reset_idle", {31'd0, idle_o}, 32'd1);
        cmp("reset_active", {28'd0, active_o}, 32'd0);
        cmp("reset_pulses", {16'd0, launch_o, kill_o, 4'd0, joined_o, all_done_o, aborted_o, timeout_o}, 32'd0);
        stepCycle();

        $display("[TB] directed JOIN");
        dv = '{3, 5, NEVER, 8};
        applyStimulus(4'b1011, 2'd0, 16'd0, dv, -1, -1);

        $display("[TB] directed JOIN_ANY");
        dv = '{NEVER, 7, 4, NEVER};
        applyStimulus(4'b0110, 2'd1, 16'd0, dv, -1, -1);

        $display("[TB] directed JOIN_NONE with abort");
        dv = '{4, NEVER, NEVER, NEVER};
        applyStimulus(4'b1111, 2'd2, 16'd0, dv, 4, -1);

        $display("[TB] directed timeout, then disabled watchdog");
        dv = '{NEVER, NEVER, NEVER, NEVER};
        applyStimulus(4'b0001, 2'd0, 16'd5, dv, -1, -1);
        dv = '{1002, NEVER, NEVER, NEVER};
        applyStimulus(4'b0001, 2'd0, 16'd0, dv, -1, -1);

        $display("[TB] directed degenerate inputs");
        applyStimulus(4'b0000, 2'd0, 16'd0, dv, -1, -1);
        dv = '{6, 9, NEVER, NEVER};
        applyStimulus(4'b0011, 2'd0, 16'd0, dv, 1, 4);
        dv = '{4, 4, 4, 4};
        applyStimulus(4'b1001, 2'd3, 16'd2, dv, -1, -1);

        $display("[TB] directed reset in DETACHED");
        sb.push_back('{cyc: cyc + 1, launch: 4'b0101, kill: 4'd0, active: 4'd0, chk_active: 1'b0,
                       joined: 1'b1, all_done: 1'b0, aborted: 1'b0, timeout: 1'b0, idle: 1'b0});
        start_i = 1'b1; mask_i = 4'b0101; mode_i = 2'd2;
        stepCycle();
        clearInputs();
        repeat (3) stepCycle();
        cmp("detached_active", {28'd0, active_o}, 32'h5);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        cmp("midreset_active", {28'd0, active_o}, 32'd0);
        cmp("midreset_idle", {31'd0, idle_o}, 32'd1);
        cmp("midreset_kill", {28'd0, kill_o}, 32'd0);
        drainCheck("pending_after_reset");
        dv = '{3, 5, NEVER, 8};
        applyStimulus(4'b1011, 2'd0, 16'd0, dv, -1, -1);

        $display("[TB] randomized groups");
        for (int g = 0; g < 60; g++) begin
            mask  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            tmo   = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            a_rel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            for (int i = 0; i < 4; i++)
                dv[i] = ($urandom_range(0, 6) == 0) ? NEVER : int'($urandom_range(2, 27));
            if (tmo == 16'd0 && a_rel < 2)
                for (int i = 0; i < 4; i++) if (dv[i] == NEVER) dv[i] = 2 + i;
            applyStimulus(mask, 2'($urandom), tmo, dv, a_rel, int'($urandom_range(1, 20)));
            repeat ($urandom_range(0, 2)) stepCycle();
        end

        cmp("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fork_join_ctrl.md
Name: fork_join_ctrl

Overview:
Hardware fork/join scheduler. It launches up to N_THREADS worker engines from one start request and tracks their completion. It signals join under JOIN, JOIN_ANY or JOIN_NONE semantics, a separate all-done event (wait-fork), and abort/kill (disable-fork) with an optional watchdog timeout. It sits between a sequencing master and a bank of worker blocks that use a launch/done pulse handshake.

Parameters:
N_THREADS, 4, number of worker slots (1..16)
TMO_W, 16, width of timeout counter and timeout_cycles_i

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
start_i  in  1  fork request; honoured only when idle_o=1
mode_i  in  2  0=JOIN, 1=JOIN_ANY, 2=JOIN_NONE, 3=reserved (treated as JOIN); sampled with start_i
mask_i  in  N_THREADS  threads to launch; sampled with start_i
timeout_cycles_i  in  TMO_W  watchdog limit in cycles; 0 disables; sampled with start_i
abort_i  in  1  disable-fork request
done_i  in  N_THREADS  per-thread completion pulse from workers
launch_o  out  N_THREADS  one-cycle launch pulse per thread
active_o  out  N_THREADS  threads launched and not yet done or killed
kill_o  out  N_THREADS  one-cycle kill pulse to still-active threads
joined_o  out  1  one-cycle pulse: join condition met
all_done_o  out  1  one-cycle pulse: every launched thread completed normally
aborted_o  out  1  one-cycle pulse: group ended by abort_i or timeout
timeout_o  out  1  one-cycle pulse, coincident with aborted_o when the watchdog fired
idle_o  out  1  1 in IDLE

Behaviour:
- Reset: state IDLE. All pulse outputs, active_o and the counter are 0; idle_o=1. Reset mid-operation drops all active threads silently, with no kill_o pulse.
- States: IDLE, LAUNCH, RUN, DETACHED.
- IDLE:
  - start_i=1 with mask_i≠0: register mode, mask and timeout; go to LAUNCH.
  - start_i=1 with mask_i=0: pulse joined_o and all_done_o at the next cycle; stay IDLE.
- LAUNCH (exactly one cycle):
  - launch_o=mask and active_o<=mask; counter cleared.
  - JOIN_NONE: joined_o pulses in this same cycle and the next state is DETACHED.
  - Otherwise next state is RUN.
  - done_i is ignored in LAUNCH; workers may assert done no earlier than the cycle after launch_o.
- RUN/DETACHED common rules:
  - active <= active & ~done_i. done_i bits for inactive threads are ignored.
  - Counter increments every cycle.
- RUN:
  - JOIN: when active becomes 0, pulse joined_o and all_done_o together in the cycle after the last done_i; go to IDLE.
  - JOIN_ANY: on the first cycle with (done_i & active)≠0, pulse joined_o in the next cycle. If active is then 0, also pulse all_done_o and go to IDLE; otherwise go to DETACHED.
- DETACHED: when active becomes 0, pulse all_done_o in the next cycle; go to IDLE. joined_o is never re-pulsed.
- Abort (abort_i=1 in RUN or DETACHED):
  - kill_o = active & ~done_i in the next cycle, together with aborted_o; active cleared; go to IDLE.
  - No joined_o or all_done_o is produced by an abort.
  - abort_i in IDLE or LAUNCH is ignored.
- Timeout: with timeout_cycles_i≠0, when the counter equals timeout_cycles_i in RUN/DETACHED, the block behaves exactly as an abort and additionally pulses timeout_o.
- Simultaneous events, in priority order:
  - rst > abort_i > timeout > done_i.
  - Exception: if the final done_i arrives in the same cycle as the timeout match, completion wins (all_done_o, no timeout_o).
- start_i outside IDLE is ignored; no queuing.
- Latency:
  - start → launch_o is 1 cycle.
  - done_i → joined_o/all_done_o is 1 cycle.
  - abort_i → kill_o/aborted_o is 1 cycle.
- All outputs are registered except active_o, which is the state register itself. idle_o is derived from the state register.

Decomposition:
- Package fork_join_pkg holds:
  - typedef enum logic[1:0] fj_mode_e {FJ_JOIN, FJ_JOIN_ANY, FJ_JOIN_NONE}
  - typedef enum fj_state_e {FJ_IDLE, FJ_LAUNCH, FJ_RUN, FJ_DETACHED}
  - localparam FJ_MAX_THREADS = 16
- One sub-module, fj_watchdog: a TMO_W counter with clear, enable, limit and a zero-disables rule, producing a one-cycle expire pulse.

Test Plan:
1. JOIN:
   - Stimulus: mask=4'b1011 at cycle 0; done_i bit0 at cycle 3, bit1 at cycle 5, bit3 at cycle 8.
   - Response: launch_o=1011 at cycle 1; joined_o and all_done_o both at cycle 9; idle_o=1 at cycle 9.
2. JOIN_ANY:
   - Stimulus: mask=4'b0110; done_i bit2 at cycle 4, bit1 at cycle 7.
   - Response: joined_o at cycle 5 with active_o=0010 afterwards; all_done_o at cycle 8, with no second joined_o.
3. JOIN_NONE then abort:
   - Stimulus: mask=4'b1111, abort_i at cycle 4, done_i bit0 also at cycle 4.
   - Response: joined_o at cycle 1; kill_o=1110 and aborted_o at cycle 5; all_done_o never asserted.
4. Timeout:
   - Stimulus: JOIN, mask=4'b0001, timeout=5, no done_i.
   - Response: timeout_o, aborted_o and kill_o=0001 all fire once; a second run with timeout=0 waits 1000 cycles without firing.
5. Degenerate and ignored inputs:
   - Stimulus: mask=0 start; start_i re-asserted during RUN; done_i on an unlaunched bit.
   - Response: the mask=0 start gives joined_o and all_done_o the next cycle with no launch_o; the RUN start produces no new launch_o; the stray done_i leaves active_o unchanged.
6. Reset mid-run:
   - Stimulus: rst asserted in DETACHED with active=0101.
   - Response: next cycle active_o=0, idle_o=1, kill_o=0, no pulses; a fresh start afterwards behaves as in scenario 1.
